// File: rtl/spi_init_sequencer_if.sv
// Handshake bundle between the init sequencer, its table ROM,
// top-level control and the SPI master.
interface spi_init_sequencer_if #(
  parameter int SPI_DATA_WIDTH = 32,
  parameter int ADDR_WIDTH     = 5
);
  logic                      i_enable;
  logic                      i_abort;
  logic [ADDR_WIDTH-1:0]     o_rom_addr;
  logic [SPI_DATA_WIDTH-1:0] i_rom_data;
  logic                      i_done;
  logic                      i_busy;
  logic                      o_enable;
  logic [SPI_DATA_WIDTH-1:0] o_data;
  logic                      o_busy;
  logic                      o_finished;
  logic                      o_error;
  logic [ADDR_WIDTH-1:0]     o_index;

  modport master (
    input  i_enable, i_abort, i_rom_data,
    input  i_done, i_busy,
    output o_rom_addr, o_enable, o_data,
    output o_busy, o_finished, o_error,
    output o_index
  );

  modport slave (
    output i_enable, i_abort, i_rom_data,
    output i_done, i_busy,
    input  o_rom_addr, o_enable, o_data,
    input  o_busy, o_finished, o_error,
    input  o_index
  );
endinterface

// File: rtl/spi_init_sequencer.sv
// Replays a ROM table of SPI writes after a dummy preamble,
// with inter-write gap, done timeout/retry, abort and status.
module spi_init_sequencer #(
  parameter int SPI_DATA_WIDTH = 32,
  parameter int NUM_DUMMY      = 3,
  parameter int NUM_WORDS      = 21,
  parameter int ADDR_WIDTH     = 5,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int MAX_RETRIES    = 2
) (
  input logic i_clock,
  input logic i_reset,
  spi_init_sequencer_if.master bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 2);
  localparam int DW = $clog2(NUM_DUMMY + 2);
  localparam int RW = $clog2(MAX_RETRIES + 2);

  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(NUM_WORDS - 1);
  localparam logic [TW-1:0] TMO_LAST =
    TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST =
    (GAP_CYCLES == 0) ? '0 : GW'(GAP_CYCLES - 1);
  localparam logic [RW-1:0] RMAX = RW'(MAX_RETRIES);
  localparam logic [DW-1:0] NDUM = DW'(NUM_DUMMY);

  typedef enum logic [3:0] {
    IDLE, DUMMY, FETCH, LOAD, ISSUE,
    WAIT_DONE, GAP, FINISH, ERROR
  } state_t;

  state_t        state;
  logic          en_s1, en_s2, en_s3;
  logic          start;
  logic [TW-1:0] tmo;
  logic [GW-1:0] gcnt;
  logic [DW-1:0] dcnt;
  logic [RW-1:0] retry;

  assign start = en_s2 & ~en_s3;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      en_s1 <= 1'b0;
      en_s2 <= 1'b0;
      en_s3 <= 1'b0;
    end else begin
      en_s1 <= bus.i_enable;
      en_s2 <= en_s1;
      en_s3 <= en_s2;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state          <= IDLE;
      tmo            <= '0;
      gcnt           <= '0;
      dcnt           <= '0;
      retry          <= '0;
      bus.o_rom_addr <= '0;
      bus.o_enable   <= 1'b0;
      bus.o_data     <= '0;
      bus.o_busy     <= 1'b0;
      bus.o_finished <= 1'b0;
      bus.o_error    <= 1'b0;
      bus.o_index    <= '0;
    end else begin
      bus.o_finished <= 1'b0;
      if (bus.i_abort && state != IDLE) begin
        state        <= IDLE;
        bus.o_enable <= 1'b0;
        bus.o_busy   <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            bus.o_enable <= 1'b0;
            if (start) begin
              bus.o_error <= 1'b0;
              bus.o_busy  <= 1'b1;
              bus.o_index <= '0;
              retry       <= '0;
              dcnt        <= NDUM;
              tmo         <= '0;
              if (NUM_DUMMY > 0) begin
                state        <= DUMMY;
                bus.o_enable <= 1'b1;
                bus.o_data   <= '0;
              end else begin
                state          <= FETCH;
                bus.o_rom_addr <= '0;
              end
            end
          end
          // dummy and table writes share done/timeout/retry
          DUMMY, WAIT_DONE: begin
            if (bus.i_done) begin
              bus.o_enable <= 1'b0;
              retry        <= '0;
              gcnt         <= '0;
              if (state == DUMMY) begin
                dcnt  <= dcnt - 1'b1;
                state <= GAP;
              end else if (bus.o_index == LAST) begin
                state          <= FINISH;
                bus.o_finished <= 1'b1;
              end else begin
                bus.o_index <= bus.o_index + 1'b1;
                state       <= GAP;
              end
            end else if (tmo == TMO_LAST) begin
              bus.o_enable <= 1'b0;
              gcnt         <= '0;
              if (retry < RMAX) begin
                retry <= retry + 1'b1;
                state <= GAP;
              end else begin
                state <= ERROR;
              end
            end else begin
              tmo <= tmo + 1'b1;
            end
          end
          FETCH: state <= LOAD;
          LOAD: begin
            bus.o_data <= bus.i_rom_data;
            state      <= ISSUE;
          end
          ISSUE: begin
            if (!bus.i_busy) begin
              bus.o_enable <= 1'b1;
              tmo          <= '0;
              state        <= WAIT_DONE;
            end
          end
          GAP: begin
            if (gcnt == GAP_LAST) begin
              if (dcnt != '0) begin
                state        <= DUMMY;
                bus.o_enable <= 1'b1;
                bus.o_data   <= '0;
                tmo          <= '0;
              end else begin
                state          <= FETCH;
                bus.o_rom_addr <= bus.o_index;
              end
            end else begin
              gcnt <= gcnt + 1'b1;
            end
          end
          FINISH: begin
            bus.o_busy  <= 1'b0;
            bus.o_index <= '0;
            state       <= IDLE;
          end
          ERROR: begin
            bus.o_error <= 1'b1;
            bus.o_busy  <= 1'b0;
            state       <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
